// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access-size encodings,
// FSM state type and the load lane-offset width helper.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    // Number of address bits selecting a byte lane inside one data word.
    function automatic int lane_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed byte/half/word/dword lane of a raw
// read word and sign- or zero-extends it to DATA_W.
// Ports: rdata_i raw word, offset_i byte offset, size_i access size,
//        unsigned_i zero-extend, data_o aligned and extended data.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFF_W = lane_off_w(DATA_W)
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] data_o
);

    localparam logic [DATA_W-1:0] MASK_B = DATA_W'(8'hFF);
    localparam logic [DATA_W-1:0] MASK_H = DATA_W'(16'hFFFF);
    localparam logic [DATA_W-1:0] MASK_W = DATA_W'(32'hFFFF_FFFF);

    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    logic              sgn;

    // Misaligned low address bits are dropped by masking the offset
    // down to the access size before the lane shift.
    always_comb begin
        off  = '0;
        mask = '1;
        sgn  = 1'b0;
        sh   = rdata_i;
        unique case (size_i)
            SZ_B: begin
                off  = offset_i;
                sh   = rdata_i >> {off, 3'b000};
                mask = MASK_B;
                sgn  = sh[7];
            end
            SZ_H: begin
                off  = offset_i & ~OFF_W'(1);
                sh   = rdata_i >> {off, 3'b000};
                mask = MASK_H;
                sgn  = sh[15];
            end
            SZ_W: begin
                off  = offset_i & ~OFF_W'(3);
                sh   = rdata_i >> {off, 3'b000};
                mask = MASK_W;
                sgn  = sh[31];
            end
            default: begin
                // dword (or word-wide on a 32-bit path): whole word
                off  = '0;
                sh   = rdata_i;
                mask = '1;
                sgn  = 1'b0;
            end
        endcase
        data_o = (sh & mask)
               | ({DATA_W{sgn && !unsigned_i}} & ~mask);
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX->WB pipeline register that waits for variable-latency
// load data, requests a stall while a load is outstanding, aligns and
// extends load data, and drives the WB and ID forwarding bundles.
// Inputs: stall_i/stall_next_i pipeline control, ex_* EX bundle,
//         dmem_rvalid_i/dmem_rdata_i read response.
// Outputs: stallreq_o, wb_* WB bundle, fwd_* forwarding bundle.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              stall_next_i,
    input  logic              ex_valid_i,
    input  logic [PC_W-1:0]   ex_pc_i,
    input  logic              ex_load_i,
    input  logic [1:0]        ex_size_i,
    input  logic              ex_unsigned_i,
    input  logic              ex_we_i,
    input  logic [RA_W-1:0]   ex_waddr_i,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              stallreq_o,
    output logic              wb_valid_o,
    output logic [PC_W-1:0]   wb_pc_o,
    output logic              wb_we_o,
    output logic [RA_W-1:0]   wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic              fwd_we_o,
    output logic [RA_W-1:0]   fwd_waddr_o,
    output logic [DATA_W-1:0] fwd_wdata_o,
    output logic              fwd_load_pending_o
);

    localparam int OFF_W = lane_off_w(DATA_W);

    logic              valid_q;
    logic [PC_W-1:0]   pc_q;
    logic              load_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              we_q;
    logic [RA_W-1:0]   waddr_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] hold_q;
    mem_state_e        state_q;

    logic              bubble;
    logic              capture;
    logic              stallreq;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] wdata;

    assign bubble  = stall_i && !stall_next_i;
    assign capture = (state_q == ST_WAIT) && dmem_rvalid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            load_q   <= 1'b0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            result_q <= '0;
            hold_q   <= '0;
            state_q  <= ST_IDLE;
        end else if (bubble) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            load_q   <= 1'b0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            result_q <= '0;
            state_q  <= ST_IDLE;
        end else if (!stall_i) begin
            valid_q  <= ex_valid_i;
            pc_q     <= ex_pc_i;
            load_q   <= ex_load_i;
            size_q   <= ex_size_i;
            uns_q    <= ex_unsigned_i;
            we_q     <= ex_we_i;
            waddr_q  <= ex_waddr_i;
            result_q <= ex_result_i;
            if (ex_valid_i && ex_load_i) begin
                // a response coinciding with the load skips WAIT
                if (dmem_rvalid_i) begin
                    hold_q  <= dmem_rdata_i;
                    state_q <= ST_DONE;
                end else begin
                    state_q <= ST_WAIT;
                end
            end else begin
                state_q <= ST_IDLE;
            end
        end else if (capture) begin
            hold_q  <= dmem_rdata_i;
            state_q <= ST_DONE;
        end
    end

    // Bypass the fresh response in its arrival cycle so the stall
    // releases without an extra bubble.
    assign raw      = capture ? dmem_rdata_i : hold_q;
    assign stallreq = (state_q == ST_WAIT) && !dmem_rvalid_i;

    load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .rdata_i    (raw),
        .offset_i   (result_q[OFF_W-1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ld_data)
    );

    assign wdata = load_q ? ld_data : result_q;

    assign stallreq_o         = stallreq;
    assign wb_valid_o         = valid_q;
    assign wb_pc_o            = pc_q;
    assign wb_we_o            = we_q && !stallreq;
    assign wb_waddr_o         = waddr_q;
    assign wb_wdata_o         = wdata;
    assign fwd_we_o           = we_q && !stallreq;
    assign fwd_waddr_o        = waddr_q;
    assign fwd_wdata_o        = wdata;
    assign fwd_load_pending_o = stallreq && we_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage, with a 32-bit and a
// 64-bit instance sharing the control stimulus.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, stall_next_i;
    logic        ex_valid, ex_load, ex_uns, ex_we;
    logic [31:0] ex_pc;
    logic [1:0]  ex_size;
    logic [4:0]  ex_waddr;
    logic [63:0] ex_result;
    logic        rvalid;
    logic [63:0] rdata;

    logic        s32, v32, we32, fwe32, pend32;
    logic [31:0] pc32, wd32, fwd32;
    logic [4:0]  wa32, fwa32;
    logic        s64, v64, we64, fwe64, pend64;
    logic [31:0] pc64;
    logic [63:0] wd64, fwd64;
    logic [4:0]  wa64, fwa64;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(32), .PC_W(32), .RA_W(5)) u32 (
        .clk(clk), .rst(rst),
        .stall_i(stall_i), .stall_next_i(stall_next_i),
        .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .ex_load_i(ex_load),
        .ex_size_i(ex_size), .ex_unsigned_i(ex_uns), .ex_we_i(ex_we),
        .ex_waddr_i(ex_waddr), .ex_result_i(ex_result[31:0]),
        .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata[31:0]),
        .stallreq_o(s32), .wb_valid_o(v32), .wb_pc_o(pc32),
        .wb_we_o(we32), .wb_waddr_o(wa32), .wb_wdata_o(wd32),
        .fwd_we_o(fwe32), .fwd_waddr_o(fwa32), .fwd_wdata_o(fwd32),
        .fwd_load_pending_o(pend32)
    );

    mem_stage #(.DATA_W(64), .PC_W(32), .RA_W(5)) u64 (
        .clk(clk), .rst(rst),
        .stall_i(stall_i), .stall_next_i(stall_next_i),
        .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .ex_load_i(ex_load),
        .ex_size_i(ex_size), .ex_unsigned_i(ex_uns), .ex_we_i(ex_we),
        .ex_waddr_i(ex_waddr), .ex_result_i(ex_result),
        .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .stallreq_o(s64), .wb_valid_o(v64), .wb_pc_o(pc64),
        .wb_we_o(we64), .wb_waddr_o(wa64), .wb_wdata_o(wd64),
        .fwd_we_o(fwe64), .fwd_waddr_o(fwa64), .fwd_wdata_o(fwd64),
        .fwd_load_pending_o(pend64)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic ld,
                          input logic [1:0] sz, input logic un,
                          input logic we, input logic [4:0] wa,
                          input logic [63:0] res);
        ex_valid  = v;
        ex_load   = ld;
        ex_size   = sz;
        ex_uns    = un;
        ex_we     = we;
        ex_waddr  = wa;
        ex_result = res;
    endtask

    initial begin
        rst = 1'b1;
        stall_i = 1'b0;
        stall_next_i = 1'b0;
        ex_pc = '0;
        rvalid = 1'b0;
        rdata = '0;
        set_ex(0, 0, SZ_B, 0, 0, 5'd0, 64'd0);
        tick();
        tick();
        check("rst_valid", 64'(v32), 64'd0);
        check("rst_we", 64'(we32), 64'd0);
        check("rst_wdata", 64'(wd32), 64'd0);
        check("rst_stall", 64'(s32), 64'd0);
        check("rst_pend", 64'(pend32), 64'd0);
        check("rst_wd64", wd64, 64'd0);
        rst = 1'b0;

        // plain ALU result
        ex_pc = 32'h100;
        set_ex(1, 0, SZ_W, 0, 1, 5'd3, 64'h1234_5678);
        tick();
        check("alu_we", 64'(we32), 64'd1);
        check("alu_waddr", 64'(wa32), 64'd3);
        check("alu_wdata", 64'(wd32), 64'h1234_5678);
        check("alu_stall", 64'(s32), 64'd0);
        check("alu_pc", 64'(pc32), 64'h100);
        check("alu_fwd", 64'(fwd32), 64'h1234_5678);

        // lb / lbu, response in the load cycle
        set_ex(1, 1, SZ_B, 0, 1, 5'd4, 64'h1002);
        rvalid = 1'b1;
        rdata = 64'h0080_0000;
        tick();
        rvalid = 1'b0;
        check("lb_wdata", 64'(wd32), 64'hFFFF_FF80);
        check("lb_stall", 64'(s32), 64'd0);
        check("lb_we", 64'(we32), 64'd1);
        set_ex(1, 1, SZ_B, 1, 1, 5'd4, 64'h1002);
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        check("lbu_wdata", 64'(wd32), 64'h0000_0080);

        // lh, response three cycles late
        set_ex(1, 1, SZ_H, 0, 1, 5'd5, 64'h2002);
        rdata = 64'h0;
        tick();
        stall_i = 1'b1;
        stall_next_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("lh_stallreq", 64'(s32), 64'd1);
            check("lh_pending", 64'(pend32), 64'd1);
            check("lh_we_off", 64'(we32), 64'd0);
            check("lh_fwe_off", 64'(fwe32), 64'd0);
            tick();
        end
        rvalid = 1'b1;
        rdata = 64'h8001_0000;
        #1;
        check("lh_resp_stall", 64'(s32), 64'd0);
        check("lh_resp_wdata", 64'(wd32), 64'hFFFF_8001);
        check("lh_resp_we", 64'(we32), 64'd1);
        check("lh_resp_pend", 64'(pend32), 64'd0);
        tick();
        rvalid = 1'b0;
        rdata = 64'h0;
        check("lh_done_wdata", 64'(wd32), 64'hFFFF_8001);

        // response while the pipeline is frozen for four cycles
        stall_i = 1'b0;
        stall_next_i = 1'b0;
        set_ex(1, 1, SZ_W, 0, 1, 5'd6, 64'h3000);
        tick();
        stall_i = 1'b1;
        stall_next_i = 1'b1;
        tick();
        rvalid = 1'b1;
        rdata = 64'hCAFE_BABE;
        tick();
        rvalid = 1'b0;
        rdata = 64'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            check("frz_wdata", 64'(wd32), 64'hCAFE_BABE);
            check("frz_stall", 64'(s32), 64'd0);
            tick();
        end

        // bubble
        stall_i = 1'b1;
        stall_next_i = 1'b0;
        tick();
        check("bub_valid", 64'(v32), 64'd0);
        check("bub_we", 64'(we32), 64'd0);
        check("bub_wdata", 64'(wd32), 64'd0);
        check("bub_pc", 64'(pc32), 64'd0);

        // hold
        stall_i = 1'b0;
        ex_pc = 32'h200;
        set_ex(1, 0, SZ_W, 0, 1, 5'd7, 64'h55);
        tick();
        stall_i = 1'b1;
        stall_next_i = 1'b1;
        ex_pc = 32'h300;
        set_ex(1, 0, SZ_W, 0, 1, 5'd9, 64'h99);
        tick();
        check("hold_wdata", 64'(wd32), 64'h55);
        check("hold_waddr", 64'(wa32), 64'd7);
        check("hold_pc", 64'(pc32), 64'h200);

        // 64-bit ld and lw at offset 4
        stall_i = 1'b0;
        stall_next_i = 1'b0;
        set_ex(1, 1, SZ_D, 0, 1, 5'd8, 64'h4000);
        rvalid = 1'b1;
        rdata = 64'h8000_0000_0000_0001;
        tick();
        check("ld64_wdata", wd64, 64'h8000_0000_0000_0001);
        set_ex(1, 1, SZ_W, 0, 1, 5'd8, 64'h4004);
        rdata = 64'h8765_4321_0000_0000;
        tick();
        rvalid = 1'b0;
        check("lw64_wdata", wd64, 64'hFFFF_FFFF_8765_4321);

        // reset in WAIT
        set_ex(1, 1, SZ_D, 0, 1, 5'd10, 64'h5000);
        tick();
        stall_i = 1'b1;
        stall_next_i = 1'b1;
        check("rw_stallreq", 64'(s64), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_stall", 64'(s64), 64'd0);
        check("rw_valid", 64'(v64), 64'd0);
        check("rw_we", 64'(we64), 64'd0);
        check("rw_wdata", wd64, 64'd0);
        rvalid = 1'b1;
        rdata = 64'h1111_2222_3333_4444;
        tick();
        rvalid = 1'b0;
        check("rw_late_we", 64'(we64), 64'd0);
        check("rw_late_wd", wd64, 64'd0);
        check("rw_late_s32", 64'(s32), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised memory-access pipeline stage between EX and WB. It registers the EX result bundle and waits for a variable-latency data-memory read response, stretching the pipeline through a stall request. Load data is byte/halfword/word(/dword) aligned and sign- or zero-extended. It drives the WB bundle and an ID forwarding bundle that flags a load still outstanding.

## Interface
Parameters:
- DATA_W, 32, data path width; 32 or 64 only.
- PC_W, 32, program-counter width.
- RA_W, 5, register-file address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  hold this stage's input register.
- stall_next_i  in  1  WB is held.
- ex_valid_i  in  1  EX bundle carries an instruction.
- ex_pc_i  in  PC_W  instruction PC.
- ex_load_i  in  1  instruction is a load.
- ex_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only).
- ex_unsigned_i  in  1  zero-extend load data.
- ex_we_i  in  1  register write enable.
- ex_waddr_i  in  RA_W  destination register.
- ex_result_i  in  DATA_W  ALU result; its low bits are the load address.
- dmem_rvalid_i  in  1  read data valid this cycle.
- dmem_rdata_i  in  DATA_W  raw read word.
- stallreq_o  out  1  load outstanding; pipeline must stall.
- wb_valid_o, wb_pc_o, wb_we_o, wb_waddr_o, wb_wdata_o  out  1/PC_W/1/RA_W/DATA_W  WB bundle.
- fwd_we_o, fwd_waddr_o, fwd_wdata_o  out  1/RA_W/DATA_W  ID forwarding bundle.
- fwd_load_pending_o  out  1  fwd_wdata_o is not yet valid.

## Operation
- Input register update order per cycle: rst clears it to 0; else stall_i && !stall_next_i loads a bubble (all 0); else !stall_i loads the ex_* inputs; else it holds.
- FSM states are IDLE, WAIT and DONE. A register load with ex_valid_i && ex_load_i enters WAIT, or DONE if dmem_rvalid_i is asserted in that same cycle. Any other load or bubble enters IDLE.
- In WAIT, dmem_rvalid_i captures dmem_rdata_i into rdata_hold and moves the FSM to DONE. dmem_rvalid_i is ignored in IDLE and DONE.
- Leaving WAIT or DONE happens only through the next register load.
- Alignment, for offset = ex_result[log2(DATA_W/8)-1:0]:
  - byte: lane = offset.
  - half: lane pair = offset>>1.
  - word: lane quad = offset>>2.
  - Misaligned low bits are ignored (the address is truncated to the access size).
  - The result is extended to DATA_W, signed unless the unsigned flag is set.
- Load data source: dmem_rdata_i in the capture cycle, otherwise rdata_hold.
- wdata = aligned load data for loads, else ex_result.
- stallreq_o = (state==WAIT) && !dmem_rvalid_i. It deasserts combinationally in the response cycle.
- The forwarding outputs mirror the WB bundle.
- fwd_load_pending_o = stallreq_o && we.
- wb_we_o and fwd_we_o are forced to 0 while stallreq_o is high, so WB never commits stale data.

## Timing
- Latency: 1 cycle from EX to WB output for non-loads; 1+k cycles for loads whose response arrives k cycles after the register load (k≥0).
- Reset: every output is 0, state=IDLE, rdata_hold=0.
- Response during stall_i (DONE reached while the pipeline is frozen for another reason): data is held in rdata_hold and presented unchanged until the register reloads.
- Reset during WAIT: returns to IDLE, stallreq_o=0 next cycle, and any late dmem_rvalid_i is ignored.
- A bubble inserted while a load is in WAIT is not possible, because a register load requires !stall_i. The upstream stall controller must OR stallreq_o into stall_i for EX and earlier.

## Structure
- Package mem_pkg holds:
  - the size encodings (SZ_B, SZ_H, SZ_W, SZ_D);
  - the FSM state enum;
  - the lane-offset width function.
- Combinational sub-module load_align (inputs DATA_W, rdata, offset, size, unsigned; output extended data) is instantiated once.
- The pipeline register and FSM live in mem_stage.

## Test plan
- ALU op, result 0x1234_5678, we=1, waddr=3, no stalls: next cycle wb_we=1, wb_waddr=3, wb_wdata=0x1234_5678, stallreq_o=0.
- lb at offset 2, rdata 0x0080_0000, rvalid with k=0: wdata=0xFFFF_FF80, no stallreq. Same access as lbu: 0x0000_0080.
- lh at offset 2, rvalid after k=3: stallreq_o high 3 cycles, fwd_load_pending_o high, wb_we_o=0. Response 0x8001_0000 gives wdata=0xFFFF_8001 in the response cycle.
- Response arrives while stall_i is held for 4 cycles: wdata stays at the captured value across all stall cycles.
- stall_i=1, stall_next_i=0: next cycle all WB outputs are 0 (bubble). stall_i=1, stall_next_i=1: outputs held.
- DATA_W=64, ld at offset 0 with rdata 0x8000_0000_0000_0001: wdata equals rdata. Reset asserted mid-WAIT: all outputs 0 next cycle, and a subsequent rvalid produces no write.
